draw_bmap_span: RTL



---
 rtl/draw_pkg.sv | 20 ++
 rtl/draw_addr_gen.sv | 43 ++++
 rtl/draw_bmap_span.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared types and helpers for the bitmap span writer.
package draw_pkg;

  // Signed 16.16 fixed-point coordinate.
  typedef logic signed [31:0] coord_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Integer part of a 16.16 coordinate (arithmetic shift, truncated to 16 bits).
  function automatic logic signed [15:0] coord_int(input coord_t c);
    return c[31:16];
  endfunction

  // Enable for one byte of the memory word: set when the byte falls inside the pixel lane.
  function automatic logic be_bit(input int unsigned byte_idx, input int unsigned lane,
                                  input int unsigned pix_bytes);
    return (byte_idx >= lane * pix_bytes) && (byte_idx < (lane + 1) * pix_bytes);
  endfunction

endpackage

// File: rtl/draw_addr_gen.sv
// Combinational clip test and framebuffer address / byte-enable generation.
module draw_addr_gen
  import draw_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned PIXEL_WIDTH = 16
) (
  input  logic signed [15:0]         i_x,
  input  logic signed [15:0]         i_y,
  input  logic [ADDR_WIDTH-1:0]      i_base,
  input  logic [15:0]                i_wmod,
  input  logic [15:0]                i_clip_x,
  input  logic [15:0]                i_clip_y,
  output logic                       o_clipped,
  output logic [ADDR_WIDTH-1:0]      o_addr,
  output logic [DATA_WIDTH/8-1:0]    o_be
);

  localparam int unsigned PIX_BYTES  = PIXEL_WIDTH / 8;
  localparam int unsigned WORD_BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS   = $clog2(WORD_BYTES);

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [ADDR_WIDTH-1:0] w_baddr;
  logic [OFF_BITS-1:0]   w_boff;
  int unsigned           w_lane;

  // Clip against [0, clip] and compute word address plus lane enables.
  always_comb begin
    o_clipped = i_x[15] | i_y[15] | ($unsigned(i_x) > i_clip_x) | ($unsigned(i_y) > i_clip_y);
    w_idx     = ADDR_WIDTH'($unsigned(i_y)) * ADDR_WIDTH'(i_wmod) + ADDR_WIDTH'($unsigned(i_x));
    w_baddr   = i_base + w_idx * ADDR_WIDTH'(PIX_BYTES);
    w_boff    = w_baddr[OFF_BITS-1:0];
    w_lane    = 32'(w_boff) / PIX_BYTES;
    o_addr    = {w_baddr[ADDR_WIDTH-1:OFF_BITS], OFF_BITS'(0)};
    o_be      = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      o_be[b] = be_bit(b, w_lane, PIX_BYTES);
    end
  end

endmodule

// File: rtl/draw_bmap_span.sv
// Walks a pixel span along a 16.16 vector, clips, skips transparent pixels and
// issues byte-enabled word writes through a one-entry write stage.
module draw_bmap_span
  import draw_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned PIXEL_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      req,
  input  logic                      abort,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [15:0]               wmod,
  input  logic [31:0]               xcur_in,
  input  logic [31:0]               ycur_in,
  input  logic [31:0]               hdx,
  input  logic [31:0]               hdy,
  input  logic [CNT_WIDTH-1:0]      cnt_in,
  input  logic [15:0]               clip_x,
  input  logic [15:0]               clip_y,
  input  logic                      transparent_en,
  output logic                      pix_req,
  input  logic                      pix_resp,
  input  logic [PIXEL_WIDTH-1:0]    pixel,
  input  logic                      pix_transparent,
  output logic                      mem_wr,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  input  logic                      mem_gnt,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_WIDTH-1:0]      wr_count
);

  state_t                  r_state, w_state_next;
  coord_t                  r_xcur, r_ycur, r_hdx, r_hdy;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [15:0]             r_wmod, r_clip_x, r_clip_y;
  logic                    r_transp_en;
  logic [CNT_WIDTH-1:0]    r_remaining;
  logic                    r_wr;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_be;
  logic [CNT_WIDTH-1:0]    r_wr_count;

  logic                    w_clipped, w_skip, w_xfer;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH/8-1:0] w_be;

  draw_addr_gen #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .PIXEL_WIDTH (PIXEL_WIDTH)
  ) u_addr_gen (
    .i_x       (coord_int(r_xcur)),
    .i_y       (coord_int(r_ycur)),
    .i_base    (r_base),
    .i_wmod    (r_wmod),
    .i_clip_x  (r_clip_x),
    .i_clip_y  (r_clip_y),
    .o_clipped (w_clipped),
    .o_addr    (w_addr),
    .o_be      (w_be)
  );

  assign w_xfer   = pix_req & pix_resp;
  assign w_skip   = w_clipped | (r_transp_en & pix_transparent);
  assign mem_wr   = r_wr;
  assign mem_addr = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be   = r_be;
  assign wr_count = r_wr_count;

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and handshake/status outputs; a fetch may overlap a granting write.
  always_comb begin
    w_state_next = r_state;
    pix_req      = 1'b0;
    busy         = (r_state != IDLE);
    done         = (r_state == DONE);
    unique case (r_state)
      IDLE: if (req) w_state_next = (cnt_in == '0) ? DONE : RUN;
      RUN: begin
        pix_req = (r_remaining != '0) && !abort && (!r_wr || mem_gnt);
        // Finish once nothing more will be fetched and the write stage drains this cycle.
        if (((r_remaining == '0) || abort) && (!r_wr || mem_gnt)) w_state_next = DONE;
      end
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latch, coordinate stepping, write stage and write counter.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_xcur      <= '0;
      r_ycur      <= '0;
      r_hdx       <= '0;
      r_hdy       <= '0;
      r_base      <= '0;
      r_wmod      <= '0;
      r_clip_x    <= '0;
      r_clip_y    <= '0;
      r_transp_en <= 1'b0;
      r_remaining <= '0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_wr_count  <= '0;
    end else begin
      if (r_state == IDLE && req) begin
        r_xcur      <= xcur_in;
        r_ycur      <= ycur_in;
        r_hdx       <= hdx;
        r_hdy       <= hdy;
        r_base      <= base_addr;
        r_wmod      <= wmod;
        r_clip_x    <= clip_x;
        r_clip_y    <= clip_y;
        r_transp_en <= transparent_en;
        r_remaining <= cnt_in;
        r_wr_count  <= '0;
      end
      if (w_xfer) begin
        r_xcur      <= r_xcur + r_hdx;
        r_ycur      <= r_ycur + r_hdy;
        r_remaining <= r_remaining - CNT_WIDTH'(1);
      end
      if (w_xfer && !w_skip) begin
        r_wr    <= 1'b1;
        r_addr  <= w_addr;
        r_wdata <= {(DATA_WIDTH / PIXEL_WIDTH){pixel}};
        r_be    <= w_be;
      end else if (mem_gnt) begin
        r_wr <= 1'b0;
      end
      if (r_wr && mem_gnt) r_wr_count <= r_wr_count + CNT_WIDTH'(1);
    end
  end

endmodule
